// File: rtl/a0_zero_demux_if.sv
// Handshake and status bundle for a0_zero_demux.
// The master side drives a0 writes, input words and consumer readies; the slave side is the demux.
interface a0_zero_demux_if;
  logic        a0_we;
  logic [15:0] a0_wdata;
  logic [15:0] demux_input;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] demux_output0;
  logic        out0_valid;
  logic        out0_ready;
  logic [15:0] demux_output1;
  logic        out1_valid;
  logic        out1_ready;
  logic [7:0]  route_cnt0;
  logic [7:0]  route_cnt1;
  logic        a0_is_zero;

  modport master (
    output a0_we, a0_wdata, demux_input, in_valid, out0_ready, out1_ready,
    input  in_ready, demux_output0, out0_valid, demux_output1, out1_valid,
           route_cnt0, route_cnt1, a0_is_zero
  );

  modport slave (
    input  a0_we, a0_wdata, demux_input, in_valid, out0_ready, out1_ready,
    output in_ready, demux_output0, out0_valid, demux_output1, out1_valid,
           route_cnt0, route_cnt1, a0_is_zero
  );
endinterface

// File: rtl/a0_zero_demux.sv
// a0_zero_demux: steers 16-bit words to output 0 when shadow a0 is zero, else to output 1.
// Define A0_FORWARD_EN to route a word by an a0 value written in the same cycle.
//
// slot state | meaning
// EMPTY      | holding register has no word for its consumer (outk_valid=0)
// FULL       | holding register presents a word to its consumer (outk_valid=1)
module a0_zero_demux (
  input  logic           clk,
  input  logic           rst,
  a0_zero_demux_if.slave bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;

  slot_t       slot0_q, slot0_d, slot1_q, slot1_d;
  logic [15:0] a0_q, data0_q, data1_q;
  logic [7:0]  cnt0_q, cnt1_q;
  logic        a0_zero, eff_zero, sel, in_ready;
  logic        accept, fill0, fill1, drain0, drain1;

  // The zero flag is derived straight from the shadow register, so it is as registered as a0_q.
  assign a0_zero = (a0_q == 16'h0000);

`ifdef A0_FORWARD_EN
  assign eff_zero = bus.a0_we ? (bus.a0_wdata == 16'h0000) : a0_zero;
`else
  assign eff_zero = a0_zero;
`endif

  assign sel      = !eff_zero;
  assign drain0   = (slot0_q == FULL) && bus.out0_ready;
  assign drain1   = (slot1_q == FULL) && bus.out1_ready;
  assign in_ready = sel ? ((slot1_q == EMPTY) || bus.out1_ready)
                        : ((slot0_q == EMPTY) || bus.out0_ready);
  assign accept   = bus.in_valid && in_ready;
  assign fill0    = accept && !sel;
  assign fill1    = accept && sel;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    case (slot0_q)
      EMPTY:   if (fill0) slot0_d = FULL;
      FULL:    if (drain0 && !fill0) slot0_d = EMPTY;
      default: slot0_d = EMPTY;
    endcase
    case (slot1_q)
      EMPTY:   if (fill1) slot1_d = FULL;
      FULL:    if (drain1 && !fill1) slot1_d = EMPTY;
      default: slot1_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_q <= EMPTY;
      slot1_q <= EMPTY;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a0_q    <= 16'h0000;
      data0_q <= 16'h0000;
      data1_q <= 16'h0000;
      cnt0_q  <= 8'h00;
      cnt1_q  <= 8'h00;
    end else begin
      if (bus.a0_we) a0_q <= bus.a0_wdata;
      if (fill0) data0_q <= bus.demux_input;
      if (fill1) data1_q <= bus.demux_input;
      if (fill0 && (cnt0_q != 8'hFF)) cnt0_q <= cnt0_q + 8'h01;
      if (fill1 && (cnt1_q != 8'hFF)) cnt1_q <= cnt1_q + 8'h01;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.demux_output0 = data0_q;
  assign bus.demux_output1 = data1_q;
  assign bus.out0_valid    = (slot0_q == FULL);
  assign bus.out1_valid    = (slot1_q == FULL);
  assign bus.route_cnt0    = cnt0_q;
  assign bus.route_cnt1    = cnt1_q;
  assign bus.a0_is_zero    = a0_zero;
endmodule

// File: tb/tb_a0_zero_demux.sv
// Bench for a0_zero_demux: directed scenarios plus random traffic against a queue-level model.
// Builds for either setting of A0_FORWARD_EN.
module tb_a0_zero_demux;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  a0_zero_demux_if bus();
  a0_zero_demux dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: what each consumer sees, how many words went each way, what a0 holds.
  bit          m_full [2];
  logic [15:0] m_data [2];
  int          m_cnt  [2];
  logic [15:0] m_a0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = 16'h0000;
      m_cnt[k]  = 0;
    end
    m_a0 = 16'h0000;
  endtask

  function automatic logic [7:0] sat(input int c);
    return (c > 255) ? 8'hFF : c[7:0];
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".v0"},   {31'b0, bus.out0_valid}, {31'b0, m_full[0]});
    chk({tag, ".v1"},   {31'b0, bus.out1_valid}, {31'b0, m_full[1]});
    chk({tag, ".d0"},   {16'b0, bus.demux_output0}, {16'b0, m_data[0]});
    chk({tag, ".d1"},   {16'b0, bus.demux_output1}, {16'b0, m_data[1]});
    chk({tag, ".c0"},   {24'b0, bus.route_cnt0}, {24'b0, sat(m_cnt[0])});
    chk({tag, ".c1"},   {24'b0, bus.route_cnt1}, {24'b0, sat(m_cnt[1])});
    chk({tag, ".zero"}, {31'b0, bus.a0_is_zero}, {31'b0, (m_a0 == 16'h0000)});
  endtask

  // Called just after a falling edge: drives one cycle, checks in_ready, advances model, checks outputs.
  task automatic step(input string tag, input logic we, input logic [15:0] wdata,
                      input logic [15:0] din, input logic vin, input logic r0, input logic r1);
    bit zero_now, rdy, acc;
    int tgt;
    bit rdy_k [2];
    bus.a0_we       = we;
    bus.a0_wdata    = wdata;
    bus.demux_input = din;
    bus.in_valid    = vin;
    bus.out0_ready  = r0;
    bus.out1_ready  = r1;
    rdy_k[0] = r0;
    rdy_k[1] = r1;
`ifdef A0_FORWARD_EN
    zero_now = we ? (wdata == 16'h0000) : (m_a0 == 16'h0000);
`else
    zero_now = (m_a0 == 16'h0000);
`endif
    tgt = zero_now ? 0 : 1;
    rdy = !m_full[tgt] || rdy_k[tgt];
    #1;
    chk({tag, ".in_ready"}, {31'b0, bus.in_ready}, {31'b0, rdy});
    acc = vin && rdy;
    for (int k = 0; k < 2; k++)
      if (m_full[k] && rdy_k[k]) m_full[k] = 1'b0;
    if (acc) begin
      m_full[tgt] = 1'b1;
      m_data[tgt] = din;
      m_cnt[tgt]++;
    end
    if (we) m_a0 = wdata;
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    logic [31:0] r;
    logic [15:0] w;
    bit ok;
    rst = 1'b1;
    bus.a0_we = 1'b0; bus.a0_wdata = 16'h0; bus.demux_input = 16'h0;
    bus.in_valid = 1'b0; bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");
    chk("reset.in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    step("first", 1'b0, 16'h0, 16'h1234, 1'b1, 1'b0, 1'b0);
    chk("first.d0", {16'b0, bus.demux_output0}, 32'h1234);
    chk("first.c0", {24'b0, bus.route_cnt0}, 32'd1);
    chk("first.v1", {31'b0, bus.out1_valid}, 32'd0);

    step("wr5", 1'b1, 16'h0005, 16'h0, 1'b0, 1'b1, 1'b0);
    step("abcd", 1'b0, 16'h0, 16'hABCD, 1'b1, 1'b0, 1'b0);
    chk("abcd.d1", {16'b0, bus.demux_output1}, 32'hABCD);
    chk("abcd.zero", {31'b0, bus.a0_is_zero}, 32'd0);
    chk("abcd.c1", {24'b0, bus.route_cnt1}, 32'd1);

    step("fwd", 1'b1, 16'h0000, 16'h5555, 1'b1, 1'b1, 1'b1);
`ifdef A0_FORWARD_EN
    chk("fwd.d0", {16'b0, bus.demux_output0}, 32'h5555);
`else
    chk("fwd.d1", {16'b0, bus.demux_output1}, 32'h5555);
`endif

    // Stall output 1 with a0 nonzero, then retarget to output 0.
    step("st_wr", 1'b1, 16'h0009, 16'h0, 1'b0, 1'b1, 1'b1);
    step("st_a", 1'b0, 16'h0, 16'hA001, 1'b1, 1'b1, 1'b0);
    step("st_b", 1'b0, 16'h0, 16'hB002, 1'b1, 1'b1, 1'b0);
    chk("st_b.hold", {16'b0, bus.demux_output1}, 32'hA001);
    step("st_b2", 1'b0, 16'h0, 16'hB002, 1'b1, 1'b1, 1'b0);
    step("st_z", 1'b1, 16'h0000, 16'hB002, 1'b0, 1'b1, 1'b0);
    step("st_c", 1'b0, 16'h0, 16'hC003, 1'b1, 1'b0, 1'b0);
    chk("st_c.d0", {16'b0, bus.demux_output0}, 32'hC003);
    chk("st_c.d1", {16'b0, bus.demux_output1}, 32'hA001);
    chk("st_c.v1", {31'b0, bus.out1_valid}, 32'd1);

    // Streaming: one word per cycle, counter saturates.
    step("sat_wr", 1'b1, 16'h0001, 16'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 300; i++)
      step("stream", 1'b0, 16'h0, 16'h4000 + 16'(i), 1'b1, 1'b1, 1'b1);
    chk("stream.last", {16'b0, bus.demux_output1}, 32'h4000 + 32'd299);
    chk("stream.sat", {24'b0, bus.route_cnt1}, 32'hFF);
    step("stream.more", 1'b0, 16'h0, 16'h7EEE, 1'b1, 1'b1, 1'b1);
    chk("stream.route", {16'b0, bus.demux_output1}, 32'h7EEE);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      w = r[31:16];
      if (r[3]) w = 16'h0000;
      step("rand", (r[2:0] == 3'd0), w, 16'($urandom), r[4] | r[5],
           r[6] | r[7], r[8] | r[9]);
    end

    // Async reset with both slots full.
    step("ar_w1", 1'b1, 16'h0003, 16'h0, 1'b0, 1'b1, 1'b1);
    step("ar_a", 1'b0, 16'h0, 16'h1111, 1'b1, 1'b0, 1'b0);
    step("ar_z", 1'b1, 16'h0000, 16'h0, 1'b0, 1'b0, 1'b0);
    step("ar_b", 1'b0, 16'h0, 16'h2222, 1'b1, 1'b0, 1'b0);
    ok = bus.out0_valid && bus.out1_valid;
    chk("ar.both_full", {31'b0, ok}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("ar.async");
    chk("ar.in_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step("ar_after", 1'b0, 16'h0, 16'h7777, 1'b1, 1'b0, 1'b0);
    chk("ar_after.d0", {16'b0, bus.demux_output0}, 32'h7777);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
